// File: rtl/subfilup_pkg.sv
// Shared definitions for the subfilup polyphase interpolator: default sizes,
// accumulator width helper and sequencer state encodings.
package subfilup_pkg;

    localparam int DEF_IW      = 16;
    localparam int DEF_OW      = 24;
    localparam int DEF_TW      = 12;
    localparam int DEF_LGNUP   = 3;
    localparam int DEF_NUP     = 5;
    localparam int DEF_LGPTAPS = 5;
    localparam int DEF_SHIFT   = 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Full-precision product plus headroom for PTAPS accumulations.
    function automatic int acc_width(input int iw, input int tw, input int lgptaps);
        return iw + tw + lgptaps;
    endfunction

endpackage

// File: rtl/subfilup_if.sv
// Sample/coefficient bus of subfilup. o_overrun exists only when
// SUBFILUP_OVERRUN_EN is defined.
interface subfilup_if
    import subfilup_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int TW = DEF_TW,
    parameter int OW = DEF_OW
) ();

    logic          i_wr_tap;
    logic [TW-1:0] i_tap;
    logic          i_ce;
    logic [IW-1:0] i_sample;
    logic          o_busy;
    logic          o_ce;
    logic [OW-1:0] o_result;
`ifdef SUBFILUP_OVERRUN_EN
    logic          o_overrun;
`endif

    modport master (
        output i_wr_tap, i_tap, i_ce, i_sample,
`ifdef SUBFILUP_OVERRUN_EN
        input  o_overrun,
`endif
        input  o_busy, o_ce, o_result
    );

    modport slave (
        input  i_wr_tap, i_tap, i_ce, i_sample,
`ifdef SUBFILUP_OVERRUN_EN
        output o_overrun,
`endif
        output o_busy, o_ce, o_result
    );

endinterface

// File: rtl/subfilup_round.sv
// Output stage: drop SHIFT MSBs of the accumulator, then round-half-to-even
// down to OW bits, registered. No saturation.
module subfilup_round
    import subfilup_pkg::*;
#(
    parameter int AW    = acc_width(DEF_IW, DEF_TW, DEF_LGPTAPS),
    parameter int OW    = DEF_OW,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic signed [AW-1:0] i_acc,
    output logic                 o_ce,
    output logic [OW-1:0]        o_result
);

    localparam int KW   = AW - SHIFT;
    localparam int DROP = KW - OW;

    logic [KW-1:0] kept, bias, sum;
    logic          o_ce_q;
    logic [OW-1:0] o_result_q;
    logic          unused_bits;

    // Bias is half-minus-one plus the kept LSB, so exact halves land on the even value.
    always_comb begin
        kept = i_acc[KW-1:0];
        bias = KW'((1 << (DROP - 1)) - 1) + KW'(kept[DROP]);
        sum  = kept + bias;
    end

    assign unused_bits = ^{i_acc[AW-1:KW], sum[DROP-1:0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ce_q     <= 1'b0;
            o_result_q <= '0;
        end else begin
            o_ce_q <= i_ce;
            if (i_ce) o_result_q <= sum[KW-1:DROP];
        end
    end

    assign o_ce     = o_ce_q;
    assign o_result = o_result_q;

endmodule

// File: rtl/subfilup.sv
// subfilup: 1:NUP polyphase interpolating FIR with one time-shared multiplier.
// Define SUBFILUP_OVERRUN_EN to get the sticky o_overrun drop flag.
module subfilup
    import subfilup_pkg::*;
#(
    parameter int IW      = DEF_IW,
    parameter int OW      = DEF_OW,
    parameter int TW      = DEF_TW,
    parameter int LGNUP   = DEF_LGNUP,
    parameter int NUP     = DEF_NUP,
    parameter int LGPTAPS = DEF_LGPTAPS,
    parameter int SHIFT   = DEF_SHIFT
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    subfilup_if.slave bus
);

    localparam int PTAPS = 1 << LGPTAPS;
    localparam int AW    = acc_width(IW, TW, LGPTAPS);
    localparam int PW    = IW + TW;
    localparam int CW    = LGNUP + LGPTAPS;

    logic signed [TW-1:0] cmem [2**CW];
    logic signed [IW-1:0] dmem [PTAPS];

    logic [LGPTAPS-1:0] wtap_q;
    logic [LGNUP-1:0]   wphase_q;
    logic [0:0]         state_q, state_d;
    logic [LGPTAPS-1:0] wraddr_q, wraddr_d, didx_q, didx_d, tidx_q, tidx_d;
    logic [LGNUP-1:0]   phase_q, phase_d;
    logic               accept, last_issue;

    logic signed [IW-1:0] rd_data_q;
    logic signed [TW-1:0] rd_coef_q;
    logic                 rd_vld_q, rd_first_q, rd_last_q;
    logic signed [PW-1:0] prod_q;
    logic                 prod_vld_q, prod_first_q, prod_last_q;
    logic signed [AW-1:0] acc_q;
    logic                 acc_done_q;

    // Coefficients load phase-major: tap index first, phase advances on tap wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wtap_q   <= '0;
            wphase_q <= '0;
        end else if (bus.i_wr_tap) begin
            wtap_q <= wtap_q + LGPTAPS'(1);
            if (&wtap_q)
                wphase_q <= (wphase_q == LGNUP'(NUP - 1)) ? '0 : wphase_q + LGNUP'(1);
        end
    end

    // NOTE: memories and their read registers have no reset; contents survive i_reset_n.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_tap) cmem[{wphase_q, wtap_q}] <= bus.i_tap;
        if (accept)       dmem[wraddr_q] <= bus.i_sample;
        rd_data_q <= dmem[didx_q];
        rd_coef_q <= cmem[{phase_q, tidx_q}];
    end

    assign accept     = bus.i_ce && (state_q == S_IDLE);
    assign last_issue = (phase_q == LGNUP'(NUP - 1)) && (&tidx_q);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d  = state_q;
        wraddr_d = wraddr_q;
        didx_d   = didx_q;
        tidx_d   = tidx_q;
        phase_d  = phase_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d  = S_RUN;
                wraddr_d = wraddr_q + LGPTAPS'(1);
                didx_d   = wraddr_q;
                tidx_d   = '0;
                phase_d  = '0;
            end
        end else begin
            // After PTAPS decrements didx is back at the newest sample for the next phase.
            didx_d = didx_q - LGPTAPS'(1);
            tidx_d = tidx_q + LGPTAPS'(1);
            if (&tidx_q)    phase_d = phase_q + LGNUP'(1);
            if (last_issue) state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            wraddr_q <= '0;
            didx_q   <= '0;
            tidx_q   <= '0;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            wraddr_q <= wraddr_d;
            didx_q   <= didx_d;
            tidx_q   <= tidx_d;
            phase_q  <= phase_d;
        end
    end

    // Read -> multiply -> accumulate; flags travel alongside the data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_q        <= '0;
            acc_done_q   <= 1'b0;
        end else begin
            rd_vld_q     <= (state_q == S_RUN);
            rd_first_q   <= (tidx_q == '0);
            rd_last_q    <= &tidx_q;
            prod_q       <= PW'(rd_data_q) * PW'(rd_coef_q);
            prod_vld_q   <= rd_vld_q;
            prod_first_q <= rd_first_q;
            prod_last_q  <= rd_last_q;
            if (prod_vld_q)
                acc_q <= prod_first_q ? AW'(prod_q) : acc_q + AW'(prod_q);
            acc_done_q   <= prod_vld_q && prod_last_q;
        end
    end

    subfilup_round #(.AW(AW), .OW(OW), .SHIFT(SHIFT)) u_round (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (acc_done_q),
        .i_acc     (acc_q),
        .o_ce      (bus.o_ce),
        .o_result  (bus.o_result)
    );

    assign bus.o_busy = (state_q == S_RUN);

`ifdef SUBFILUP_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                      overrun_q <= 1'b0;
        else if (bus.i_ce && !accept)        overrun_q <= 1'b1;
    end

    assign bus.o_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_subfilup.sv
// Scoreboard bench for subfilup: stimulus pushes expected (value, cycle) pairs,
// a negedge monitor pops and compares on every o_ce.
module tb_subfilup;

    localparam int IW    = 16;
    localparam int TW    = 12;
    localparam int OW    = 24;
    localparam int NUP   = 5;
    localparam int PTAPS = 32;
    localparam int LAT   = PTAPS + 4;
    localparam int GAP   = NUP * PTAPS;

    typedef struct {
        logic [OW-1:0] val;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t sb[$];
    exp_t mon_e;

    logic signed [TW-1:0] m_c [NUP][PTAPS];
    logic signed [IW-1:0] m_d [PTAPS];
    int                   m_wr = 0;

    subfilup_if bus ();

    subfilup dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent model: 31-bit wrap after dropping 2 MSBs of the 33-bit sum, then
    // floor by 128 and bump when the remainder is above half, or exactly half with odd quotient.
    function automatic logic [OW-1:0] rnd(input longint a);
        longint v, q, r;
        v = (a <<< 33) >>> 33;
        q = v >>> 7;
        r = v - (q <<< 7);
        if (r > 64 || (r == 64 && q[0])) q++;
        return q[OW-1:0];
    endfunction

    function automatic longint model_acc(input int p, input int n);
        longint a = 0;
        for (int t = 0; t < PTAPS; t++)
            a += longint'(m_c[p][t]) * longint'(m_d[(n - t + PTAPS) % PTAPS]);
        return a;
    endfunction

    function automatic int tapval(input int mode, input int p, input int t);
        case (mode)
            1:       return (t < 3) ? p * 100 + t * 37 - 150 : 0;
            2:       return (t == 0) ? 1024 : 0;
            3: begin
                if (t != 0) return 0;
                case (p)
                    0:       return 64;
                    1:       return 192;
                    2:       return -64;
                    3:       return 65;
                    default: return -192;
                endcase
            end
            default: return 0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_taps(input int mode);
        int v;
        for (int p = 0; p < NUP; p++)
            for (int t = 0; t < PTAPS; t++) begin
                v = tapval(mode, p, t);
                m_c[p][t]    = v[TW-1:0];
                bus.i_tap    = v[TW-1:0];
                bus.i_wr_tap = 1'b1;
                @(negedge clk);
            end
        bus.i_wr_tap = 1'b0;
    endtask

    // Called on a negedge; holds i_ce for one cycle.
    task automatic send(input int s, input bit acc, input string nm);
        exp_t e;
        check({nm, " o_busy"}, 64'(bus.o_busy), 64'(!acc));
        bus.i_sample = s[IW-1:0];
        bus.i_ce     = 1'b1;
        if (acc) begin
            m_d[m_wr] = s[IW-1:0];
            for (int p = 0; p < NUP; p++) begin
                e.val = rnd(model_acc(p, m_wr));
                e.due = cyc + LAT + p * PTAPS;
                sb.push_back(e);
            end
            m_wr = (m_wr + 1) % PTAPS;
        end
        @(negedge clk);
        bus.i_ce = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < GAP + 80) begin
            @(negedge clk);
            n++;
        end
        check("drain queue empty", 64'(sb.size()), 64'(0));
        idle(4);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_ce) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected o_ce: got result %0h expected no pulse (cycle %0d)",
                         bus.o_result, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("o_result", 64'(bus.o_result), 64'(mon_e.val));
                check("o_ce cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_wr_tap = 1'b0;
        bus.i_tap    = '0;
        bus.i_ce     = 1'b0;
        bus.i_sample = '0;
        for (int i = 0; i < PTAPS; i++) m_d[i] = '0;
        #2 rst_n = 1'b0;
        idle(3);
        check("reset o_ce", 64'(bus.o_ce), 64'(0));
        check("reset o_result", 64'(bus.o_result), 64'(0));
        check("reset o_busy", 64'(bus.o_busy), 64'(0));
        rst_n = 1'b1;
        idle(2);

        // Zero taps and fill the sample history with zeros at the minimum input period.
        load_taps(0);
        for (int i = 0; i < PTAPS; i++) begin
            send(0, 1'b1, "flush");
            idle(GAP);
        end
        wait_drain();

        // Impulse then zeros: outputs walk the coefficients, 1<<14 * c / 128 = 128 * c.
        load_taps(1);
        send(1 << (IW - 2), 1'b1, "impulse");
        idle(GAP);
        send(0, 1'b1, "impulse z1");
        idle(GAP);
        send(0, 1'b1, "impulse z2");
        wait_drain();

        // Tap 0 of every phase = 1<<10, input 1000 -> five outputs of 8000.
`ifdef SUBFILUP_OVERRUN_EN
        check("overrun clear", 64'(bus.o_overrun), 64'(0));
`endif
        load_taps(2);
        send(1000, 1'b1, "scale");
        send(555, 1'b0, "drop");
`ifdef SUBFILUP_OVERRUN_EN
        check("overrun set", 64'(bus.o_overrun), 64'(1));
`endif
        wait_drain();
`ifdef SUBFILUP_OVERRUN_EN
        check("overrun sticky", 64'(bus.o_overrun), 64'(1));
`endif

        // Three inputs at the minimum period; across a burst boundary the o_ce gap
        // is PTAPS+1 because the input period is NUP*PTAPS+1.
        send(100, 1'b1, "period s0");
        idle(GAP);
        send(-200, 1'b1, "period s1");
        idle(GAP);
        send(300, 1'b1, "period s2");
        wait_drain();

        // Reset in the middle of a run clears outputs at once and aborts the burst.
        send(777, 1'b1, "abort");
        idle(50);
        rst_n = 1'b0;
        sb.delete();
        m_wr = 0;
        #1;
        check("mid-run reset o_ce", 64'(bus.o_ce), 64'(0));
        check("mid-run reset o_result", 64'(bus.o_result), 64'(0));
        check("mid-run reset o_busy", 64'(bus.o_busy), 64'(0));
`ifdef SUBFILUP_OVERRUN_EN
        check("overrun reset", 64'(bus.o_overrun), 64'(0));
`endif
        idle(2);
        rst_n = 1'b1;
        idle(GAP);
        send(-1000, 1'b1, "after reset");
        wait_drain();

        // Exact halves: 64->0, 192->2, -64->0, 65->1, -192->-2.
        load_taps(3);
        send(1, 1'b1, "round");
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
